// File: rtl/inst_fetch_req_pkg.sv
// Shared fetch definitions: CP0 reset vector, fetch exception codes and the output-buffer entry.
package inst_fetch_req_pkg;

  localparam logic [31:0] CP0_RESET_PC = 32'hBFC0_0000;
  localparam logic [4:0]  EXC_AdEL     = 5'h04;
  localparam logic [4:0]  EXC_NONE     = 5'h00;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        exc;
    logic [4:0]  exccode;
  } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_req_if.sv
// Instruction SRAM-like bus between the fetch unit (master) and the memory side (slave).
interface inst_fetch_req_if;

  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );

endinterface

// File: rtl/inst_fetch_req_chk.sv
// Protocol checks for inst_fetch_req: no response without an outstanding request, no FIFO overflow.
module inst_fetch_req_chk (
  input logic clk,
  input logic reset,
  input logic data_ok,
  input logic inflight_zero,
  input logic tag_overflow,
  input logic buf_overflow
);

  a_no_orphan_data_ok: assert property (@(posedge clk) disable iff (reset) !(data_ok && inflight_zero));
  a_no_tag_overflow:   assert property (@(posedge clk) disable iff (reset) !tag_overflow);
  a_no_buf_overflow:   assert property (@(posedge clk) disable iff (reset) !buf_overflow);

endmodule

// File: rtl/inst_fetch_req_sync_fifo.sv
// Generic synchronous FIFO with combinational head; clr empties it, push+pop allowed when full.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clr,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ZERO = {(AW+1){1'b0}};
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push_s;
  logic             do_pop_s;

  always_comb begin
    do_pop_s  = pop && (count_q != CNT_ZERO);
    do_push_s = push && ((count_q != CNT_FULL) || do_pop_s);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (clr) begin
      wr_ptr_d = {AW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
      count_d  = CNT_ZERO;
    end else begin
      if (do_push_s) wr_ptr_d = wr_ptr_q + PTR_ONE;
      else           wr_ptr_d = wr_ptr_q;
      if (do_pop_s)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      else           rd_ptr_d = rd_ptr_q;
      count_d = count_q + {{AW{1'b0}}, do_push_s} - {{AW{1'b0}}, do_pop_s};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= CNT_ZERO;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count_q alone decides which slots are valid.
  always_ff @(posedge clk) begin
    if (do_push_s && !clr && !reset) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CNT_FULL);
  assign empty = (count_q == CNT_ZERO);

endmodule

// File: rtl/inst_fetch_req.sv
// Instruction fetch request unit: credit-limited fetch, in-order tagging, flush/drop on redirect or reset.
// Optional INST_FETCH_PERF_EN adds the discard_cnt port counting dropped responses.
module inst_fetch_req
  import inst_fetch_req_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = CP0_RESET_PC
) (
  input  logic                   clk,
  input  logic                   reset,
  inst_fetch_req_if.master       inst_sram,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_pc,
  output logic [31:0]            out_inst,
  output logic                   out_exc,
  output logic [4:0]             out_exccode
`ifdef INST_FETCH_PERF_EN
  ,
  output logic [31:0]            discard_cnt
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = CW + 1;
  localparam logic [TW-1:0] CREDITS  = TW'(DEPTH);
  localparam logic [TW-1:0] TW_ZERO  = {TW{1'b0}};
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [31:0]   pc_q, pc_d;
  logic          halted_q, halted_d;
  logic [CW-1:0] drop_q, drop_d;

  logic [CW-1:0] tag_count_s, ob_count_s;
  logic [31:0]   tag_head_s;
  logic          tag_full_s, tag_empty_s, ob_full_s, ob_empty_s;
  fetch_entry_t  ob_head_s, ob_push_data_s;

  logic [TW-1:0] inflight_s, occupancy_s;
  logic [CW-1:0] drop_reload_s;
  logic          req_s, accept_s, resp_valid_s, resp_drop_s, resp_keep_s;
  logic          tag_pop_s, exc_push_s, ob_push_s, ob_pop_s;

  // Outstanding responses are tagged ones plus those already marked for dropping.
  always_comb begin
    inflight_s    = {1'b0, tag_count_s} + {1'b0, drop_q};
    occupancy_s   = inflight_s + {1'b0, ob_count_s};
    req_s         = !reset && !redirect_valid && (pc_q[1:0] == 2'b00)
                    && (occupancy_s < CREDITS) && !halted_q;
    accept_s      = req_s && inst_sram.addr_ok;
    resp_valid_s  = inst_sram.data_ok && (inflight_s != TW_ZERO);
    resp_drop_s   = resp_valid_s && ((drop_q != CNT_ZERO) || redirect_valid || reset);
    resp_keep_s   = resp_valid_s && !resp_drop_s;
    tag_pop_s     = inst_sram.data_ok && (drop_q == CNT_ZERO) && !tag_empty_s;
    drop_reload_s = CW'(inflight_s - {{CW{1'b0}}, resp_valid_s});
    exc_push_s    = !reset && !redirect_valid && (pc_q[1:0] != 2'b00)
                    && (inflight_s == TW_ZERO) && !ob_full_s && !halted_q;
    ob_push_s     = resp_keep_s || exc_push_s;
    ob_pop_s      = out_valid && out_ready;
    if (exc_push_s) begin
      ob_push_data_s = '{pc: pc_q, inst: 32'h0000_0000, exc: 1'b1, exccode: EXC_AdEL};
    end else begin
      ob_push_data_s = '{pc: tag_head_s, inst: inst_sram.rdata, exc: 1'b0, exccode: EXC_NONE};
    end
  end

  // Redirect flushes everything younger and turns every outstanding response into a drop.
  always_comb begin
    pc_d     = pc_q;
    halted_d = halted_q;
    drop_d   = drop_q;
    if (redirect_valid) begin
      pc_d     = redirect_pc;
      halted_d = 1'b0;
      drop_d   = drop_reload_s;
    end else begin
      if (accept_s) pc_d = pc_q + 32'd4;
      else          pc_d = pc_q;
      if (exc_push_s) halted_d = 1'b1;
      else            halted_d = halted_q;
      if (resp_valid_s && (drop_q != CNT_ZERO)) drop_d = drop_q - CNT_ONE;
      else                                      drop_d = drop_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
      drop_q   <= drop_reload_s;
    end else begin
      pc_q     <= pc_d;
      halted_q <= halted_d;
      drop_q   <= drop_d;
    end
  end

`ifdef INST_FETCH_PERF_EN
  logic [31:0] discard_q, discard_d;

  always_comb begin
    if (resp_drop_s && (discard_q != 32'hFFFF_FFFF)) discard_d = discard_q + 32'd1;
    else                                             discard_d = discard_q;
  end

  always_ff @(posedge clk) begin
    if (reset) discard_q <= 32'h0000_0000;
    else       discard_q <= discard_d;
  end

  assign discard_cnt = discard_q;
`endif

  sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_tag_fifo (
    .clk       (clk),
    .reset     (reset),
    .clr       (redirect_valid),
    .push      (accept_s),
    .push_data (pc_q),
    .pop       (tag_pop_s),
    .head      (tag_head_s),
    .count     (tag_count_s),
    .full      (tag_full_s),
    .empty     (tag_empty_s)
  );

  sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_out_buf (
    .clk       (clk),
    .reset     (reset),
    .clr       (redirect_valid),
    .push      (ob_push_s),
    .push_data (ob_push_data_s),
    .pop       (ob_pop_s),
    .head      (ob_head_s),
    .count     (ob_count_s),
    .full      (ob_full_s),
    .empty     (ob_empty_s)
  );

  inst_fetch_req_chk u_chk (
    .clk           (clk),
    .reset         (reset),
    .data_ok       (inst_sram.data_ok),
    .inflight_zero (inflight_s == TW_ZERO),
    .tag_overflow  (accept_s && tag_full_s && !tag_pop_s),
    .buf_overflow  (ob_push_s && ob_full_s && !ob_pop_s)
  );

  assign inst_sram.req   = req_s;
  assign inst_sram.wr    = 1'b0;
  assign inst_sram.size  = 2'd2;
  assign inst_sram.wstrb = 4'b1111;
  assign inst_sram.addr  = pc_q;
  assign inst_sram.wdata = 32'h0000_0000;

  assign out_valid   = !ob_empty_s;
  assign out_pc      = ob_head_s.pc;
  assign out_inst    = ob_head_s.inst;
  assign out_exc     = ob_head_s.exc;
  assign out_exccode = ob_head_s.exccode;

endmodule
